// File: rtl/ps2_keyboard_tracker_pkg.sv
// PS/2 set-2 scan code constants, decoder state encoding and event layout.
package ps2_scan_code_set2;

  // Prefix bytes
  localparam logic [7:0] CodeE0 = 8'hE0;
  localparam logic [7:0] CodeE1 = 8'hE1;
  localparam logic [7:0] CodeF0 = 8'hF0;

  // Modifier codes (Ctrl/Alt share a code between plain and E0 forms)
  localparam logic [7:0] CodeShiftL = 8'h12;
  localparam logic [7:0] CodeShiftR = 8'h59;
  localparam logic [7:0] CodeCtrl   = 8'h14;
  localparam logic [7:0] CodeAlt    = 8'h11;
  localparam logic [7:0] CodeMetaL  = 8'h1F;
  localparam logic [7:0] CodeMetaR  = 8'h27;

  // Lock codes (plain only)
  localparam logic [7:0] CodeCaps   = 8'h58;
  localparam logic [7:0] CodeNum    = 8'h77;
  localparam logic [7:0] CodeScroll = 8'h7E;

  // Fake shifts the keyboard wraps around some E0 keys
  localparam logic [7:0] CodeFakeShiftL = 8'h12;
  localparam logic [7:0] CodeFakeShiftR = 8'h59;

  // Pause sequence body bytes
  localparam logic [7:0] CodePause1 = 8'h14;
  localparam logic [7:0] CodePause2 = 8'h77;

  // Bit positions in the modifier vector
  localparam logic [2:0] ModShiftL = 3'd0;
  localparam logic [2:0] ModShiftR = 3'd1;
  localparam logic [2:0] ModCtrlL  = 3'd2;
  localparam logic [2:0] ModCtrlR  = 3'd3;
  localparam logic [2:0] ModAlt    = 3'd4;
  localparam logic [2:0] ModAltGr  = 3'd5;
  localparam logic [2:0] ModMetaL  = 3'd6;
  localparam logic [2:0] ModMetaR  = 3'd7;

  // Bit positions in the lock vector
  localparam logic [1:0] LockCaps   = 2'd0;
  localparam logic [1:0] LockNum    = 2'd1;
  localparam logic [1:0] LockScroll = 2'd2;

  typedef enum logic [2:0] {
    StIdle          = 3'd0,
    StE0            = 3'd1,
    StE1First       = 3'd2,
    StE1Second      = 3'd3,
    StBreak         = 3'd4,
    StE0Break       = 3'd5,
    StE1FirstBreak  = 3'd6,
    StE1SecondBreak = 3'd7
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] modifiers;
    logic       brk;
    logic       extended;
    logic [7:0] code;
  } ps2_event_t;

  localparam int unsigned EventWidth = $bits(ps2_event_t);

  function automatic logic is_fake_shift(logic [7:0] code);
    return (code == CodeFakeShiftL) || (code == CodeFakeShiftR);
  endfunction

endpackage

// File: rtl/ps2_keyboard_tracker_if.sv
// Scan byte input and key event output bundle of the keyboard tracker.
interface ps2_keyboard_tracker_if;
  logic       scan_code_ready;
  logic [7:0] scan_code_in;
  logic       event_valid;
  logic       event_ready;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_break;
  logic [7:0] event_modifiers;
  logic [7:0] modifiers;
  logic [2:0] locks;
  logic       locks_changed;
  logic       overflow;

  // Tracker side
  modport master (
    input  scan_code_ready, scan_code_in, event_ready,
    output event_valid, event_code, event_extended, event_break, event_modifiers,
    output modifiers, locks, locks_changed, overflow
  );

  // Byte source / event consumer side
  modport slave (
    output scan_code_ready, scan_code_in, event_ready,
    input  event_valid, event_code, event_extended, event_break, event_modifiers,
    input  modifiers, locks, locks_changed, overflow
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO; head is valid whenever empty is low.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0] count_q;
  logic do_push, do_pop;

  assign empty = (count_q == '0);
  assign full = (count_q == CntFull);
  assign do_pop = pop && !empty;
  // A push into a full FIFO is still taken when a pop frees a slot this cycle
  assign do_push = push && (!full || do_pop);
  assign head = mem_q[rd_ptr_q];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10: count_q <= count_q + CntOne;
        2'b01: count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/ps2_keyboard_tracker.sv
// PS/2 set-2 decoder: prefix FSM, modifier/lock tracking, repeat filter and event FIFO.
module ps2_keyboard_tracker
  import ps2_scan_code_set2::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit REPORT_BREAK = 1'b1,
  parameter bit REPORT_MODIFIERS = 1'b0,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input logic clk,
  input logic reset,
  ps2_keyboard_tracker_if.master bus
);
  ps2_state_e state_q, state_d;

  logic key_valid, key_ext, key_brk;
  logic [7:0] code;
  logic mod_hit, lock_hit;
  logic [2:0] mod_idx;
  logic [1:0] lock_idx;
  logic same_key, is_repeat, suppressed, lock_toggle, enqueue;

  logic [7:0] modifiers_q;
  logic [2:0] locks_q;
  logic locks_changed_q;
  logic [7:0] last_code_q;
  logic last_ext_q, held_q;
  logic push_q;
  ps2_event_t push_data_q;
  logic overflow_q;

  logic fifo_full, fifo_empty, fifo_pop;
  logic [EventWidth-1:0] head_raw;
  ps2_event_t head;

  assign code = bus.scan_code_in;

  // Prefix decoding: next state and the key event (if any) carried by this byte
  always_comb begin
    state_d = state_q;
    key_valid = 1'b0;
    key_ext = 1'b0;
    key_brk = 1'b0;
    if (bus.scan_code_ready) begin
      unique case (state_q)
        StIdle: begin
          if (code == CodeE0) state_d = StE0;
          else if (code == CodeE1) state_d = StE1First;
          else if (code == CodeF0) state_d = StBreak;
          else key_valid = 1'b1;
        end
        StE0: begin
          state_d = StIdle;
          if (code == CodeF0) begin
            state_d = StE0Break;
          end else if (!is_fake_shift(code)) begin
            key_valid = 1'b1;
            key_ext = 1'b1;
          end
        end
        StE1First: begin
          if (code == CodePause1) state_d = StE1Second;
          else if (code == CodeF0) state_d = StE1FirstBreak;
          else state_d = StIdle;
        end
        StE1Second: begin
          state_d = StIdle;
          if (code == CodePause2) begin
            // Pause reported as an extended make of its last byte
            key_valid = 1'b1;
            key_ext = 1'b1;
          end else if (code == CodeF0) begin
            state_d = StE1SecondBreak;
          end
        end
        StBreak: begin
          state_d = StIdle;
          key_valid = 1'b1;
          key_brk = 1'b1;
        end
        StE0Break: begin
          state_d = StIdle;
          if (!is_fake_shift(code)) begin
            key_valid = 1'b1;
            key_ext = 1'b1;
            key_brk = 1'b1;
          end
        end
        StE1FirstBreak: state_d = StE1Second;
        StE1SecondBreak: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Classify the key as modifier and/or lock
  always_comb begin
    mod_hit = 1'b1;
    mod_idx = '0;
    unique case ({key_ext, code})
      {1'b0, CodeShiftL}: mod_idx = ModShiftL;
      {1'b0, CodeShiftR}: mod_idx = ModShiftR;
      {1'b0, CodeCtrl}: mod_idx = ModCtrlL;
      {1'b0, CodeAlt}: mod_idx = ModAlt;
      {1'b1, CodeCtrl}: mod_idx = ModCtrlR;
      {1'b1, CodeAlt}: mod_idx = ModAltGr;
      {1'b1, CodeMetaL}: mod_idx = ModMetaL;
      {1'b1, CodeMetaR}: mod_idx = ModMetaR;
      default: mod_hit = 1'b0;
    endcase
    lock_hit = !key_ext;
    lock_idx = '0;
    unique case (code)
      CodeCaps: lock_idx = LockCaps;
      CodeNum: lock_idx = LockNum;
      CodeScroll: lock_idx = LockScroll;
      default: lock_hit = 1'b0;
    endcase
  end

  assign same_key = held_q && (last_code_q == code) && (last_ext_q == key_ext);
  assign is_repeat = key_valid && !key_brk && same_key;
  assign suppressed = SUPPRESS_REPEAT && is_repeat;
  assign lock_toggle = key_valid && !key_brk && lock_hit && !suppressed;
  assign enqueue = key_valid && !suppressed && (REPORT_BREAK || !key_brk) &&
                   (REPORT_MODIFIERS || !(mod_hit || lock_hit));

  // Decoder state, live key state, repeat register and the staged FIFO write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      modifiers_q <= '0;
      locks_q <= '0;
      locks_changed_q <= 1'b0;
      last_code_q <= '0;
      last_ext_q <= 1'b0;
      held_q <= 1'b0;
      push_q <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q <= state_d;
      locks_changed_q <= lock_toggle;
      push_q <= enqueue;
      if (key_valid) begin
        if (mod_hit) modifiers_q[mod_idx] <= !key_brk;
        if (lock_toggle) locks_q[lock_idx] <= !locks_q[lock_idx];
        if (!key_brk) begin
          last_code_q <= code;
          last_ext_q <= key_ext;
          held_q <= 1'b1;
        end else if (same_key) begin
          held_q <= 1'b0;
        end
        // Snapshot is the vector before this key's own update
        if (enqueue) begin
          push_data_q <= '{modifiers: modifiers_q, brk: key_brk, extended: key_ext, code: code};
        end
      end
    end
  end

  assign fifo_pop = bus.event_ready && !fifo_empty;

  // Drop indication for a staged event that finds the FIFO full with no pop
  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else overflow_q <= push_q && fifo_full && !fifo_pop;
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EventWidth)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_q),
    .push_data(push_data_q),
    .pop(fifo_pop),
    .head(head_raw),
    .full(fifo_full),
    .empty(fifo_empty)
  );

  assign head = ps2_event_t'(head_raw);

  assign bus.event_valid = !fifo_empty;
  assign bus.event_code = fifo_empty ? '0 : head.code;
  assign bus.event_extended = fifo_empty ? 1'b0 : head.extended;
  assign bus.event_break = fifo_empty ? 1'b0 : head.brk;
  assign bus.event_modifiers = fifo_empty ? '0 : head.modifiers;
  assign bus.modifiers = modifiers_q;
  assign bus.locks = locks_q;
  assign bus.locks_changed = locks_changed_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ps2_keyboard_tracker.sv
// Bench for ps2_keyboard_tracker: byte-stream reference model, directed and random stimulus.
module tb_ps2_keyboard_tracker;
  localparam int unsigned Depth = 4;
  localparam bit RepBreak = 1'b1;
  localparam bit RepMods = 1'b0;
  localparam bit SupRep = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ps2_keyboard_tracker_if bus ();

  ps2_keyboard_tracker #(
    .FIFO_DEPTH(Depth),
    .REPORT_BREAK(RepBreak),
    .REPORT_MODIFIERS(RepMods),
    .SUPPRESS_REPEAT(SupRep)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    bit ext;
    bit brk;
    logic [7:0] mods;
  } ev_t;

  // Reference model state
  ev_t m_q[$];
  ev_t m_stage;
  bit m_stage_valid;
  logic [7:0] m_mods;
  logic [2:0] m_locks;
  bit m_lc, m_ovf;
  logic [7:0] m_seq[$];
  logic [7:0] m_last_code;
  bit m_last_ext, m_held;

  int n_tests = 0;
  int n_fail = 0;
  int lc_seen, ovf_seen, pops_seen;
  string phase = "init";

  logic [7:0] pool [16] = '{8'hE0, 8'hE1, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11,
                            8'h1F, 8'h27, 8'h58, 8'h77, 8'h7E, 8'h1C, 8'h7C, 8'h32};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", phase, tag, got, exp);
    end
  endtask

  function automatic int mod_bit(bit ext, logic [7:0] c);
    if (!ext) begin
      case (c)
        8'h12: return 0;
        8'h59: return 1;
        8'h14: return 2;
        8'h11: return 4;
        default: return -1;
      endcase
    end
    case (c)
      8'h14: return 3;
      8'h11: return 5;
      8'h1F: return 6;
      8'h27: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int lock_bit(bit ext, logic [7:0] c);
    if (ext) return -1;
    case (c)
      8'h58: return 0;
      8'h77: return 1;
      8'h7E: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic bit fake(logic [7:0] c);
    return (c == 8'h12) || (c == 8'h59);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_seq.delete();
    m_stage_valid = 0;
    m_mods = '0;
    m_locks = '0;
    m_lc = 0;
    m_ovf = 0;
    m_last_code = '0;
    m_last_ext = 0;
    m_held = 0;
  endtask

  // Apply one decoded key to the live state and stage its event
  task automatic model_key(input bit ext, input bit brk, input logic [7:0] c);
    int mb;
    int lb;
    bit rep;
    bit drop;
    ev_t e;
    mb = mod_bit(ext, c);
    lb = lock_bit(ext, c);
    rep = !brk && m_held && (m_last_code == c) && (m_last_ext == ext);
    drop = SupRep && rep;
    e.code = c;
    e.ext = ext;
    e.brk = brk;
    e.mods = m_mods;
    if (mb >= 0) m_mods[mb] = !brk;
    if (!brk && lb >= 0 && !drop) begin
      m_locks[lb] = ~m_locks[lb];
      m_lc = 1;
    end
    if (!brk) begin
      m_last_code = c;
      m_last_ext = ext;
      m_held = 1;
    end else if (m_held && m_last_code == c && m_last_ext == ext) begin
      m_held = 0;
    end
    if (brk && !RepBreak) drop = 1;
    if ((mb >= 0 || lb >= 0) && !RepMods) drop = 1;
    if (!drop) begin
      m_stage = e;
      m_stage_valid = 1;
    end
  endtask

  // Accumulate bytes until they form a complete sequence, then interpret it
  task automatic model_byte(input logic [7:0] b);
    m_seq.push_back(b);
    if (m_seq[0] == 8'hE0) begin
      if (m_seq.size() == 2 && b != 8'hF0) begin
        if (!fake(b)) model_key(1, 0, b);
        m_seq.delete();
      end else if (m_seq.size() == 3) begin
        if (!fake(b)) model_key(1, 1, b);
        m_seq.delete();
      end
    end else if (m_seq[0] == 8'hE1) begin
      if (m_seq.size() == 2) begin
        if (b != 8'h14 && b != 8'hF0) m_seq.delete();
      end else if (m_seq.size() == 3) begin
        if (m_seq[1] == 8'hF0) begin
          // Released first body byte: continue as if E1 14 had been seen
          m_seq.delete();
          m_seq.push_back(8'hE1);
          m_seq.push_back(8'h14);
        end else if (b == 8'h77) begin
          model_key(1, 0, b);
          m_seq.delete();
        end else if (b != 8'hF0) begin
          m_seq.delete();
        end
      end else if (m_seq.size() == 4) begin
        m_seq.delete();
      end
    end else if (m_seq[0] == 8'hF0) begin
      if (m_seq.size() == 2) begin
        model_key(0, 1, b);
        m_seq.delete();
      end
    end else begin
      model_key(0, 0, b);
      m_seq.delete();
    end
  endtask

  task automatic compare_outputs();
    check("valid", bus.event_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("code", bus.event_code, m_q[0].code);
      check("ext", bus.event_extended, m_q[0].ext);
      check("brk", bus.event_break, m_q[0].brk);
      check("emods", bus.event_modifiers, m_q[0].mods);
    end
    check("mods", bus.modifiers, m_mods);
    check("locks", bus.locks, m_locks);
    check("lc", bus.locks_changed, m_lc);
    check("ovf", bus.overflow, m_ovf);
  endtask

  // One clock: drive inputs, advance the model across the edge, compare after it
  task automatic step(input bit stb, input logic [7:0] b, input bit rdy);
    bit full;
    bit pop;
    bus.scan_code_ready = stb;
    bus.scan_code_in = b;
    bus.event_ready = rdy;
    if (bus.event_valid && rdy) pops_seen++;
    full = (m_q.size() == Depth);
    pop = rdy && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    m_ovf = 0;
    if (m_stage_valid) begin
      if (!full || pop) m_q.push_back(m_stage);
      else m_ovf = 1;
    end
    m_stage_valid = 0;
    m_lc = 0;
    if (stb) model_byte(b);
    @(posedge clk);
    #1;
    compare_outputs();
    if (bus.locks_changed) lc_seen++;
    if (bus.overflow) ovf_seen++;
  endtask

  task automatic send(input logic [7:0] bytes[$], input bit rdy);
    foreach (bytes[i]) step(1, bytes[i], rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.scan_code_ready = 1'b0;
    bus.scan_code_in = '0;
    bus.event_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    lc_seen = 0;
    ovf_seen = 0;
    pops_seen = 0;
    check("rst_valid", bus.event_valid, 0);
    check("rst_code", bus.event_code, 0);
    check("rst_ext", bus.event_extended, 0);
    check("rst_brk", bus.event_break, 0);
    check("rst_emods", bus.event_modifiers, 0);
    check("rst_mods", bus.modifiers, 0);
    check("rst_locks", bus.locks, 0);
    check("rst_lc", bus.locks_changed, 0);
    check("rst_ovf", bus.overflow, 0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return pool[r];
    return 8'($urandom);
  endfunction

  initial begin
    bus.scan_code_ready = 1'b0;
    bus.scan_code_in = '0;
    bus.event_ready = 1'b0;

    phase = "make_break";
    do_reset();
    step(1, 8'h1C, 0);
    check("valid_1cyc", bus.event_valid, 0);
    step(0, 8'h00, 0);
    check("valid_2cyc", bus.event_valid, 1);
    send('{8'hF0, 8'h1C}, 1);
    idle(4, 1);
    check("pops", pops_seen, 2);

    phase = "shift_repeat";
    do_reset();
    send('{8'h12, 8'h1C, 8'h1C, 8'h1C}, 1);
    check("shift_held", bus.modifiers, 8'h01);
    send('{8'hF0, 8'h1C, 8'hF0, 8'h12}, 1);
    idle(4, 1);
    check("pops", pops_seen, 2);
    check("mods_end", bus.modifiers, 8'h00);

    phase = "extended";
    do_reset();
    send('{8'hE0, 8'h12, 8'hE0, 8'h7C, 8'hE0, 8'h11}, 1);
    idle(4, 1);
    check("pops", pops_seen, 1);
    check("altgr", bus.modifiers[5], 1);

    phase = "locks";
    do_reset();
    step(1, 8'h58, 1);
    check("caps_on", bus.locks, 3'b001);
    send('{8'h58, 8'hF0, 8'h58, 8'h58}, 1);
    idle(4, 1);
    check("caps_off", bus.locks, 3'b000);
    check("lc_pulses", lc_seen, 2);
    check("pops", pops_seen, 0);

    phase = "pause";
    do_reset();
    send('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 1);
    idle(4, 1);
    check("pops", pops_seen, 1);
    send('{8'h1C}, 1);
    idle(4, 1);
    check("pops_after", pops_seen, 2);

    phase = "overflow";
    do_reset();
    send('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24}, 0);
    idle(3, 0);
    check("ovf_once", ovf_seen, 1);
    step(1, 8'h2B, 0);
    step(0, 8'h00, 1);
    idle(3, 0);
    check("ovf_still_once", ovf_seen, 1);
    check("pops_mid", pops_seen, 1);
    idle(8, 1);
    check("pops_total", pops_seen, 5);

    phase = "mid_reset";
    do_reset();
    send('{8'hE0}, 1);
    do_reset();
    send('{8'h12}, 1);
    check("plain_shift", bus.modifiers, 8'h01);
    idle(2, 1);

    phase = "random";
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 600; i++) begin
        step($urandom_range(0, 99) < 55, rand_byte(), $urandom_range(0, 99) < rdy_pct);
      end
      if (seg == 3) do_reset();
    end
    idle(10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_tracker.md
# ps2_keyboard_tracker

Parametrised PS/2 set-2 keyboard decoder. It sits between the PS/2 byte receiver and the terminal input logic. It turns raw scan bytes into key events, with make/break flag, extended flag and a modifier snapshot, and tracks modifier and lock-key state. It also suppresses typematic repeats and buffers events in a small FIFO with a valid/ready handshake, so the consumer can stall without losing keys.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- REPORT_BREAK, 1: 1 = break events are queued; 0 = only make events are queued.
- REPORT_MODIFIERS, 0: 1 = modifier and lock keys are also queued as events.
- SUPPRESS_REPEAT, 1: 1 = a typematic repeat of the last held key is not queued.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- scan_code_ready  in  1  one-cycle strobe; scan_code_in is valid.
- scan_code_in  in  8  raw set-2 byte.
- event_valid  out  1  FIFO non-empty.
- event_ready  in  1  consumer pops the head when event_valid is high and event_ready is high.
- event_code  out  8  head entry: scan code.
- event_extended  out  1  head entry: E0 or E1 prefixed.
- event_break  out  1  head entry: 1 = release.
- event_modifiers  out  8  head entry: modifier vector at enqueue time.
- modifiers  out  8  live vector {meta_r, meta_l, altgr, alt, ctrl_r, ctrl_l, shift_r, shift_l} (bit 7 down to bit 0).
- locks  out  3  live {scroll, num, caps}.
- locks_changed  out  1  one-cycle pulse when `locks` changes (drives LED update).
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Decoder FSM states (3 bits): IDLE, E0, E1_1, E1_2, BREAK, E0_BREAK, E1_1_BREAK, E1_2_BREAK. It advances only on scan_code_ready.
- IDLE:
  - E0 → E0.
  - E1 → E1_1.
  - F0 → BREAK.
  - Any other byte is a make of a plain key → IDLE.
- E0:
  - F0 → E0_BREAK.
  - 12 or 59 (fake shift) → IDLE with no effect.
  - Any other byte is an extended make → IDLE.
- BREAK: the byte is a plain break → IDLE.
- E0_BREAK: the byte is an extended break → IDLE; fake shifts are ignored here too.
- Pause sequence E1 14 77 E1 F0 14 F0 77:
  - E1_1: 14 → E1_2; F0 → E1_1_BREAK; any other byte → IDLE.
  - E1_2: 77 produces an extended make with code 77, then → IDLE; F0 → E1_2_BREAK; any other byte → IDLE.
  - E1_1_BREAK consumes one byte → E1_2.
  - E1_2_BREAK consumes one byte → IDLE and produces no event.
- Modifier keys:
  - Plain: 12 = shift_l, 59 = shift_r, 14 = ctrl_l, 11 = alt.
  - Extended: 14 = ctrl_r, 11 = altgr, 1F = meta_l, 27 = meta_r.
  - Make sets the bit; break clears it.
- Lock keys (plain): 58 = caps, 77 = num, 7E = scroll.
  - A non-repeat make toggles the lock bit and pulses locks_changed.
  - Break has no effect on the lock bit.
- Repeat filter:
  - The block stores the last make as {code, extended} plus a held flag.
  - A make equal to the stored make while held is a repeat. With SUPPRESS_REPEAT=1 a repeat is not queued and does not toggle a lock.
  - A break of the stored key clears held.
  - A make of a different key replaces the stored key.
- Enqueue rules:
  - Breaks are dropped when REPORT_BREAK=0.
  - Modifier and lock keys are dropped when REPORT_MODIFIERS=0.
  - event_modifiers records the modifier vector before this event's own update.
- FIFO full on push:
  - With no simultaneous pop, the new event is dropped, overflow pulses, and state updates still apply.
  - A push and a pop in the same cycle while full are both accepted.
- Pop while empty is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - FIFO empty, so event_valid = 0.
  - event_code, event_extended, event_break and event_modifiers = 0.
  - modifiers = 0, locks = 0.
  - locks_changed = 0, overflow = 0.
  - Repeat register cleared.
- Reset in the middle of a multi-byte sequence discards it, and the FIFO contents are lost.
- modifiers, locks and locks_changed update in the cycle after the scan_code_ready strobe.
- Event path:
  - The event is written at the clock edge after the strobe.
  - event_valid rises one cycle later, i.e. 2 cycles after the strobe when the FIFO is empty.
- FIFO head outputs are show-ahead (the head entry is presented without a read) and hold stable while event_valid is high and event_ready is low.
- Back-to-back strobes on consecutive cycles must be accepted.

## Structure
- Package ps2_scan_code_set2 holds the prefix constants (E0, E1, F0), the modifier and lock codes, the fake-shift codes, the pause bytes, the FSM state encoding, and the modifier bit indices.
- Sub-module ps2_event_fifo: synchronous show-ahead FIFO, width 18 ({modifiers, break, extended, code}), depth FIFO_DEPTH, with full/empty flags.

## Test plan
- Bytes 1C, F0 1C with defaults → two events: {1C, ext=0, brk=0, mods=00}, then {1C, ext=0, brk=1, mods=00}; event_valid first rises 2 cycles after the first strobe.
- Bytes 12, 1C, 1C, 1C, F0 1C, F0 12 → modifiers = 01 while shift is held; only one make for 1C (mods=01) plus its break; modifiers = 00 at the end.
- Bytes E0 12 E0 7C (print screen), then E0 11 → fake shift ignored; one event {7C, ext=1}; modifiers bit 5 (altgr) = 1.
- Bytes 58, 58 (repeat), F0 58, 58 → locks = 001 after the first make, then 000 after the second non-repeat make; exactly 2 locks_changed pulses; no events queued.
- Full pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {77, ext=1, brk=0}; state ends in IDLE.
- event_ready held low with FIFO_DEPTH=4, then 5 distinct makes → 4 events queued and overflow pulses once. Then pop and push in the same cycle while full → occupancy stays 4, with no loss and no overflow.
